// File: rtl/mazesolver_gpio_ctrl_if.sv
// mazesolver_gpio_ctrl_if: Avalon-MM slave bus between the Nios II and the GPIO block
interface mazesolver_gpio_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
  modport slave (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);
endinterface

// File: rtl/mazesolver_gpio_ctrl.sv
// mazesolver_gpio_ctrl: LED driver with blink, debounced keys, sticky press capture and maskable irq
module mazesolver_gpio_ctrl #(
  parameter int LED_W           = 8,
  parameter int KEY_W           = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 25000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  mazesolver_gpio_ctrl_if.slave  avs,
  output logic                   irq,
  output logic [LED_W-1:0]       led_wire_export,
  input  logic [KEY_W-1:0]       key_1_wire_export
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [KEY_W-1:0] REL = {KEY_W{KEY_ACTIVE_LOW}};
  logic [LED_W-1:0] led_data_q, led_data_d, blink_mask_q, blink_mask_d, led_q, led_d;
  logic [KEY_W-1:0] irq_mask_q, irq_mask_d, edge_cap_q, edge_cap_d;
  logic [KEY_W-1:0] sync1_q, sync2_q, key_n, deb_q, deb_d;
  logic [KEY_W-1:0][DW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] pre_q, pre_d;
  logic phase_q, phase_d, irq_q, irq_d, wr, wrap;
  logic [2:0] wa;
  logic [31:0] wd, rd_val, rdata_q, rdata_d;
  assign wr = avs.avs_write;
  assign wa = avs.avs_address;
  assign wd = avs.avs_writedata;
  assign key_n = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign wrap = pre_q == BW'(BLINK_DIV - 1);
  // per-key debounce: accept the synced level only after it has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < KEY_W; i++) begin
      if (key_n[i] == deb_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i] = key_n[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + DW'(1);
    end
  end
  // register writes, press capture (a press beats a same-cycle clear), blink prescaler and outputs
  always_comb begin
    led_data_d   = (wr && wa == 3'd0) ? wd[LED_W-1:0] :
                   (wr && wa == 3'd1) ? led_data_q | wd[LED_W-1:0] :
                   (wr && wa == 3'd2) ? led_data_q & ~wd[LED_W-1:0] : led_data_q;
    blink_mask_d = (wr && wa == 3'd3) ? wd[LED_W-1:0] : blink_mask_q;
    irq_mask_d   = (wr && wa == 3'd5) ? wd[KEY_W-1:0] : irq_mask_q;
    edge_cap_d   = (edge_cap_q & ~((wr && wa == 3'd6) ? wd[KEY_W-1:0] : '0)) | (deb_d & ~deb_q);
    irq_d        = |(edge_cap_q & irq_mask_q);
    pre_d        = wrap ? '0 : pre_q + BW'(1);
    phase_d      = phase_q ^ wrap;
    led_d        = led_data_q & ~(blink_mask_q & {LED_W{phase_q}});
  end
  // read mux; readdata holds between reads
  always_comb begin
    case (wa)
      3'd0:    rd_val = 32'(led_data_q);
      3'd3:    rd_val = 32'(blink_mask_q);
      3'd4:    rd_val = 32'(deb_q);
      3'd5:    rd_val = 32'(irq_mask_q);
      3'd6:    rd_val = 32'(edge_cap_q);
      3'd7:    rd_val = {8'hA5, 8'(LED_W), 8'(KEY_W), 8'h02};
      default: rd_val = '0;
    endcase
    rdata_d = avs.avs_read ? rd_val : rdata_q;
  end
  // state registers; synchronisers reset to the released pin level
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      led_data_q   <= '0;
      blink_mask_q <= '0;
      irq_mask_q   <= '0;
      edge_cap_q   <= '0;
      sync1_q      <= REL;
      sync2_q      <= REL;
      deb_q        <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      phase_q      <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
      led_q        <= '0;
    end else begin
      led_data_q   <= led_data_d;
      blink_mask_q <= blink_mask_d;
      irq_mask_q   <= irq_mask_d;
      edge_cap_q   <= edge_cap_d;
      sync1_q      <= key_1_wire_export;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      phase_q      <= phase_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
      led_q        <= led_d;
    end
  end
  assign avs.avs_readdata = rdata_q;
  assign irq = irq_q;
  assign led_wire_export = led_q;
endmodule

// File: tb/tb_mazesolver_gpio_ctrl.sv
// tb_mazesolver_gpio_ctrl: directed bench with a read scoreboard for the GPIO controller
module tb_mazesolver_gpio_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  logic [7:0] led;
  logic [0:0] key = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] q[$];
  logic [7:0] prev, v, other;
  bit found;
  mazesolver_gpio_ctrl_if bus();
  mazesolver_gpio_ctrl #(.LED_W(8), .KEY_W(1), .DEBOUNCE_CYCLES(4), .BLINK_DIV(3), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs(bus), .irq(irq),
    .led_wire_export(led), .key_1_wire_export(key));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] e);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    q.push_back(e);
    @(negedge clk);
    bus.avs_read = 1'b0;
    chk(tag, bus.avs_readdata, q.pop_front());
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    cyc(2);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_rdata", bus.avs_readdata, 0);
    rst_n = 1'b1;
    rd("id", 3'd7, 32'hA5080102);
    rd("led_rst", 3'd0, 0);
    rd("key_rst", 3'd4, 0);
    rd("cap_rst", 3'd6, 0);
    wr(3'd0, 32'h5A);
    wr(3'd1, 32'h81);
    wr(3'd2, 32'h08);
    chk("led_pin_prev", 32'(led), 32'hDB);
    cyc(1);
    chk("led_pin", 32'(led), 32'hD3);
    rd("led_data", 3'd0, 32'hD3);
    rd("led_set_rd", 3'd1, 0);
    rd("led_clr_rd", 3'd2, 0);
    key = 1'b0;
    cyc(3);
    key = 1'b1;
    cyc(8);
    rd("glitch_key", 3'd4, 0);
    rd("glitch_cap", 3'd6, 0);
    bus.avs_address = 3'd4;
    bus.avs_read = 1'b1;
    key = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      q.push_back(32'(i >= 7));
      @(negedge clk);
      chk($sformatf("deb_timing_%0d", i), bus.avs_readdata, q.pop_front());
    end
    bus.avs_read = 1'b0;
    rd("press_cap", 3'd6, 1);
    chk("irq_masked", 32'(irq), 0);
    wr(3'd5, 1);
    chk("irq_lat", 32'(irq), 0);
    cyc(1);
    chk("irq_set", 32'(irq), 1);
    rd("irq_mask", 3'd5, 1);
    wr(3'd6, 0);
    cyc(1);
    chk("irq_w0", 32'(irq), 1);
    rd("cap_w0", 3'd6, 1);
    wr(3'd6, 1);
    cyc(1);
    chk("irq_clr", 32'(irq), 0);
    rd("cap_clr", 3'd6, 0);
    key = 1'b1;
    cyc(8);
    rd("release_key", 3'd4, 0);
    rd("release_cap", 3'd6, 0);
    key = 1'b0;
    cyc(5);
    wr(3'd6, 1);
    cyc(1);
    chk("race_irq", 32'(irq), 1);
    rd("race_cap", 3'd6, 1);
    wr(3'd0, 32'hFF);
    wr(3'd3, 32'h0F);
    rd("blink_mask", 3'd3, 32'h0F);
    cyc(2);
    found = 1'b0;
    prev = led;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (led !== prev) found = 1'b1;
      else prev = led;
    end
    chk("blink_align", 32'(found), 1);
    v = led;
    chk("blink_val", 32'(v == 8'hFF || v == 8'hF0), 1);
    other = (v == 8'hFF) ? 8'hF0 : 8'hFF;
    for (int j = 1; j <= 9; j++) q.push_back(32'(((j / 3) % 2 == 0) ? v : other));
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      chk($sformatf("blink_%0d", j), 32'(led), q.pop_front());
    end
    wr(3'd3, 0);
    cyc(2);
    for (int j = 0; j < 6; j++) begin
      q.push_back(32'hFF);
      @(negedge clk);
      chk($sformatf("steady_%0d", j), 32'(led), q.pop_front());
    end
    rd("id_pre_rst", 3'd7, 32'hA5080102);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_led", 32'(led), 0);
    chk("mid_rst_rdata", bus.avs_readdata, 0);
    key = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    rd("post_rst_mask", 3'd5, 0);
    rd("post_rst_cap", 3'd6, 0);
    rd("post_rst_led", 3'd0, 0);
    rd("post_rst_blink", 3'd3, 0);
    rd("post_rst_key", 3'd4, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mazesolver_gpio_ctrl.md
Name: mazesolver_gpio_ctrl

Overview:
Parametrised Avalon-MM GPIO peripheral replacing the fixed 8-bit LED PIO and single-key PIO in the mazesolver SoC. Drives LED_W LEDs with optional per-bit blink, and samples KEY_W push-buttons through a synchroniser and debouncer. Captures press edges into a sticky register and raises a maskable level interrupt to the Nios II.

Parameters:
LED_W, 8, number of LED outputs (1..32)
KEY_W, 1, number of key inputs (1..32)
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a key change (>=2)
BLINK_DIV, 25000000, clk cycles per blink phase toggle (>=1)
KEY_ACTIVE_LOW, 1, 1 = key pressed when pin is 0

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  3  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, valid 1 cycle after avs_read
irq  out  1  level interrupt, active-high
led_wire_export  out  LED_W  LED drive
key_1_wire_export  in  KEY_W  raw key pins, asynchronous

Behaviour:
- Reset (async assert, sync deassert via the reset_reset_n tree): led_data=0, blink_mask=0, irq_mask=0, edge_cap=0, debounced key state = released, sync FFs = released level, counters=0, blink phase=0, avs_readdata=0, irq=0, led_wire_export=0.
- Register map (word addresses); unused bits read 0; writes to RO/undefined addresses are ignored:
  0 LED_DATA RW [LED_W-1:0]
  1 LED_SET W: led_data |= wdata; reads 0
  2 LED_CLR W: led_data &= ~wdata; reads 0
  3 BLINK_MASK RW [LED_W-1:0]
  4 KEY_STATE RO debounced key state, 1 = pressed (after polarity)
  5 IRQ_MASK RW [KEY_W-1:0]
  6 EDGE_CAP RW1C [KEY_W-1:0]
  7 ID RO {8'hA5, 8'(LED_W), 8'(KEY_W), 8'h02}
- Read latency fixed at 1: avs_readdata is registered from avs_address when avs_read=1; it holds its value otherwise. No waitrequest.
- Key path per bit: 2-FF synchroniser, then polarity-normalised. Counter cnt counts while synced != debounced and resets to 0 when they are equal. When cnt reaches DEBOUNCE_CYCLES-1 with mismatch still present, debounced <= synced and cnt <= 0. A glitch shorter than DEBOUNCE_CYCLES never changes state. Counter width = clog2(DEBOUNCE_CYCLES).
- Total latency from pin change to KEY_STATE change = 2 (sync) + DEBOUNCE_CYCLES cycles.
- Press event = debounced 0->1 transition; sets edge_cap bit in the same cycle as the debounced update. Releases do not set edge_cap.
- EDGE_CAP write: bits written 1 are cleared. A press event in the same cycle as a clearing write on the same bit wins (bit stays 1).
- irq registered: irq <= |(edge_cap & irq_mask); asserts 1 cycle after edge_cap set or mask enable; deasserts 1 cycle after clear/mask.
- Blink: prescaler counts 0..BLINK_DIV-1 then wraps and toggles phase. led_wire_export = led_data & ~(blink_mask & {LED_W{phase}}), registered (1-cycle latency from register write to pin).
- Simultaneous LED_SET/LED_CLR cannot occur (single port). A write to LED_DATA fully overwrites.
- Reset asserted mid-debounce or mid-blink aborts immediately to reset values; there are no partial updates.

Test Plan:
- Reset: assert reset_reset_n=0 mid-operation -> all outputs 0; read ID (addr 7) after release with LED_W=8, KEY_W=1 -> 32'hA5080102.
- LED ops: write 0x5A to addr 0, write 0x81 to addr 1, write 0x08 to addr 2 -> addr 0 reads 0xD3; led_wire_export=0xD3 one cycle after the last write.
- Debounce (DEBOUNCE_CYCLES=4, active-low): drive pin 0 for 3 cycles, then 1 -> KEY_STATE stays 0 and edge_cap stays 0. Drive pin 0 steadily -> KEY_STATE=1 exactly 6 cycles after the pin edge; edge_cap[0]=1.
- IRQ: with edge_cap[0]=1, write IRQ_MASK=1 -> irq=1 the next cycle. Write 1 to addr 6 -> edge_cap=0, irq=0 the next cycle. Write 0 to addr 6 -> no change.
- Clear/set race: issue a clearing write to EDGE_CAP in the same cycle as a debounced press -> edge_cap[0] remains 1 and irq stays asserted.
- Blink (BLINK_DIV=3): led_data=0xFF, blink_mask=0x0F -> led_wire_export alternates 0xFF/0xF0 every 3 cycles. Write blink_mask=0 -> steady 0xFF.
